// File: rtl/posit_round_pack_es3.sv
// Rounds and packs an unrounded es=3 posit product into a 32-bit posit; latency 3 cycles after the input edge.
// No backpressure: one item per cycle, start=0 cycles become bubbles that never raise done.
module posit_round_pack_es3 #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int SBITS = 10,
  parameter int MBITS = 54,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SBITS+MBITS+2:0]   in_raw,
  output logic [NBITS-1:0]         result,
  output logic                     done,
  output logic [CNTW-1:0]          sat_cnt
);

  localparam int FW  = NBITS - 1;
  localparam int FW1 = FW + 1;
  localparam int PAD = NBITS + 5;
  localparam int WW  = 2 + ES + MBITS + PAD;
  localparam logic signed [SBITS-1:0] SAT_HI = SBITS'((NBITS - 2) << ES);
  localparam logic signed [SBITS-1:0] SAT_LO = -SAT_HI;
  localparam logic [FW-1:0] MAG_ONE = {{(FW-1){1'b0}}, 1'b1};

  // input capture
  logic                   v0;
  logic [SBITS+MBITS+2:0] raw0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0   <= 1'b0;
      raw0 <= '0;
    end else begin
      v0 <= 1'b0;
      if (start) begin
        v0   <= 1'b1;
        raw0 <= in_raw;
      end
    end
  end

  // S1: regime decode
  logic                    sgn0, inf0, zero0, ovf0, unf0;
  logic signed [SBITS-1:0] scale0, k0;
  logic [SBITS-1:0]        sh0;
  logic [MBITS-1:0]        frac0;

  always_comb begin
    sgn0   = raw0[SBITS+MBITS+2];
    scale0 = raw0[SBITS+MBITS+1:MBITS+2];
    frac0  = raw0[MBITS+1:2];
    inf0   = raw0[1];
    zero0  = raw0[0];
    k0     = scale0 >>> ES;
    // the terminated run is produced by an arithmetic shift; a negative k needs -k-1 == ~k
    sh0    = k0[SBITS-1] ? ~k0 : k0;
    ovf0   = scale0 > SAT_HI;
    unf0   = scale0 < SAT_LO;
  end

  logic                   v1, sgn1, inf1, zero1, ovf1, unf1, neg1;
  logic [ES-1:0]          e1;
  logic [MBITS-1:0]       frac1;
  logic [SBITS-1:0]       sh1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      sgn1  <= 1'b0;
      inf1  <= 1'b0;
      zero1 <= 1'b0;
      ovf1  <= 1'b0;
      unf1  <= 1'b0;
      neg1  <= 1'b0;
      e1    <= '0;
      frac1 <= '0;
      sh1   <= '0;
    end else begin
      v1    <= v0;
      sgn1  <= sgn0;
      inf1  <= inf0;
      zero1 <= zero0;
      ovf1  <= ovf0;
      unf1  <= unf0;
      neg1  <= k0[SBITS-1];
      e1    <= scale0[ES-1:0];
      frac1 <= frac0;
      sh1   <= sh0;
    end
  end

  // S2: the padding is wide enough that no bit is lost inside the legal scale range
  logic signed [WW-1:0] str1, shifted1;

  always_comb begin
    str1     = {(neg1 ? 2'b01 : 2'b10), e1, frac1, {PAD{1'b0}}};
    shifted1 = str1 >>> sh1;
  end

  logic          v2, sgn2, inf2, zero2, ovf2, unf2, g2, st2;
  logic [FW-1:0] mag2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2    <= 1'b0;
      sgn2  <= 1'b0;
      inf2  <= 1'b0;
      zero2 <= 1'b0;
      ovf2  <= 1'b0;
      unf2  <= 1'b0;
      g2    <= 1'b0;
      st2   <= 1'b0;
      mag2  <= '0;
    end else begin
      v2    <= v1;
      sgn2  <= sgn1;
      inf2  <= inf1;
      zero2 <= zero1;
      ovf2  <= ovf1;
      unf2  <= unf1;
      mag2  <= shifted1[WW-1 -: FW];
      g2    <= shifted1[WW-1-FW];
      st2   <= |shifted1[WW-2-FW:0];
    end
  end

  // S3: round, saturate, sign, specials
  logic             inc3, sat3;
  logic [FW:0]      sum3;
  logic [FW-1:0]    rnd3, mag3;
  logic [NBITS-1:0] packed3;

  always_comb begin
    inc3 = g2 & (st2 | mag2[0]);
    sum3 = {1'b0, mag2} + FW1'(inc3);
    rnd3 = sum3[FW] ? {FW{1'b1}} : sum3[FW-1:0];
    if (rnd3 == '0) rnd3 = MAG_ONE;
    mag3 = rnd3;
    if (ovf2)      mag3 = {FW{1'b1}};
    else if (unf2) mag3 = MAG_ONE;
    packed3 = sgn2 ? {1'b1, ~mag3 + MAG_ONE} : {1'b0, mag3};
    if (inf2)       packed3 = {1'b1, {FW{1'b0}}};
    else if (zero2) packed3 = '0;
    sat3 = v2 & ~inf2 & ~zero2 & (ovf2 | unf2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result  <= '0;
      done    <= 1'b0;
      sat_cnt <= '0;
    end else begin
      done <= v2;
      if (v2) result <= packed3;
      if (sat3 && (sat_cnt != {CNTW{1'b1}})) sat_cnt <= sat_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_posit_round_pack_es3.sv
// Bench for posit_round_pack_es3: directed vectors plus random stream against a bit-string posit model.
module tb_posit_round_pack_es3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [66:0] in_raw;
  logic [31:0] result;
  logic        done;
  logic [15:0] sat_cnt;

  posit_round_pack_es3 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_raw  (in_raw),
    .result  (result),
    .done    (done),
    .sat_cnt (sat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected output timeline: index 0 is the item driven now, index 4 is what the outputs show now
  bit          pv[5];
  logic [31:0] pr[5];
  logic [15:0] pc[5];
  int          model_cnt;
  logic [31:0] hold;

  function automatic logic [66:0] mk(input bit sg, input int sc, input logic [53:0] fr,
                                     input bit inf, input bit zr);
    return {sg, sc[9:0], fr, inf, zr};
  endfunction

  function automatic logic [31:0] ref_posit(input logic [66:0] raw, output bit sat);
    int     sc, k, e;
    bit     q[$];
    longint mag, nm;
    bit     guard, sticky;
    logic [31:0] res;
    sc  = int'($signed(raw[65:56]));
    sat = 1'b0;
    if (raw[1]) return 32'h8000_0000;
    if (raw[0]) return 32'h0000_0000;
    if (sc > 240) begin
      mag = 64'h7FFF_FFFF;
      sat = 1'b1;
    end else if (sc < -240) begin
      mag = 1;
      sat = 1'b1;
    end else begin
      k = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
      e = sc - 8 * k;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 53; i >= 2 - 2; i--) q.push_back(raw[2 + i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + longint'(q[i]);
      guard  = q[31];
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky = sticky | q[i];
      if (guard && (sticky || mag[0])) mag = mag + 1;
      if (mag >= 64'h8000_0000) mag = 64'h7FFF_FFFF;
      if (mag == 0) mag = 1;
    end
    if (raw[66]) begin
      nm  = 64'h8000_0000 - mag;
      res = {1'b1, nm[30:0]};
    end else begin
      res = {1'b0, mag[30:0]};
    end
    return res;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 5; i++) begin
      pv[i] = 1'b0;
      pr[i] = '0;
      pc[i] = '0;
    end
    model_cnt = 0;
    hold      = '0;
  endtask

  task automatic step(input bit s, input logic [66:0] raw);
    bit          sat;
    logic [31:0] r;
    @(negedge clk);
    for (int i = 4; i > 0; i--) begin
      pv[i] = pv[i-1];
      pr[i] = pr[i-1];
      pc[i] = pc[i-1];
    end
    r = ref_posit(raw, sat);
    if (s && sat && model_cnt < 65535) model_cnt++;
    pv[0] = s;
    pr[0] = r;
    pc[0] = 16'(model_cnt);
    if (pv[4]) hold = pr[4];
    start  = s;
    in_raw = raw;
  endtask

  function automatic logic [66:0] rand_raw();
    logic [53:0] fr;
    int          sc;
    bit          inf, zr;
    fr  = {22'($urandom), $urandom};
    sc  = int'($urandom_range(520)) - 260;
    inf = ($urandom_range(15) == 0);
    zr  = ($urandom_range(15) == 0);
    return mk(1'($urandom), sc, fr, inf, zr);
  endfunction

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b0;
    in_raw = '0;
    clear_model();
    #12;
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got %h want %h", result, 32'h0); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sat_cnt !== 16'h0) begin failures++; $display("FAIL reset_sat_cnt got %h want 0", sat_cnt); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_done got %b want 0", done); end
    end
  endtask

  task automatic test_directed();
    logic [66:0] vr[12];
    logic [31:0] vx[12];
    logic [15:0] vc[12];
    vr[0]  = mk(0, 0, 54'h0, 0, 0);                               vx[0]  = 32'h4000_0000; vc[0]  = 0;
    vr[1]  = mk(1, 0, 54'h0, 0, 0);                               vx[1]  = 32'hC000_0000; vc[1]  = 0;
    vr[2]  = mk(0, 0, 54'h1 << 27, 0, 0);                         vx[2]  = 32'h4000_0000; vc[2]  = 0;
    vr[3]  = mk(0, 0, (54'h1 << 28) | (54'h1 << 27), 0, 0);       vx[3]  = 32'h4000_0002; vc[3]  = 0;
    vr[4]  = mk(0, 0, (54'h1 << 27) | 54'h1, 0, 0);               vx[4]  = 32'h4000_0001; vc[4]  = 0;
    vr[5]  = mk(0, 241, 54'h0, 0, 0);                             vx[5]  = 32'h7FFF_FFFF; vc[5]  = 1;
    vr[6]  = mk(1, -241, 54'h0, 0, 0);                            vx[6]  = 32'hFFFF_FFFF; vc[6]  = 2;
    vr[7]  = mk(0, 240, 54'h0, 0, 0);                             vx[7]  = 32'h7FFF_FFFF; vc[7]  = 2;
    vr[8]  = mk(0, 241, 54'h0, 0, 1);                             vx[8]  = 32'h0000_0000; vc[8]  = 2;
    vr[9]  = mk(0, 241, 54'h0, 1, 1);                             vx[9]  = 32'h8000_0000; vc[9]  = 2;
    vr[10] = mk(0, -240, 54'h0, 0, 0);                            vx[10] = 32'h0000_0001; vc[10] = 2;
    vr[11] = mk(0, -1, 54'h0, 0, 0);                              vx[11] = 32'h3C00_0000; vc[11] = 2;
    for (int v = 0; v < 12; v++) begin
      step(1'b1, vr[v]);
      for (int j = 1; j <= 4; j++) begin
        step(1'b0, '0);
        if (j < 4) begin
          checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir%0d_early_done cyc %0d got %b want 0", v, j, done); end
        end
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL dir%0d_done got %b want 1", v, done); end
      checks++; if (result !== vx[v]) begin failures++; $display("FAIL dir%0d_result got %h want %h", v, result, vx[v]); end
      checks++; if (sat_cnt !== vc[v]) begin failures++; $display("FAIL dir%0d_sat_cnt got %h want %h", v, sat_cnt, vc[v]); end
    end
  endtask

  task automatic test_back_to_back();
    int scs[4] = '{-20, 5, 77, -130};
    int ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b1, mk(1'(i), scs[i], {22'($urandom), $urandom}, 0, 0));
      else       step(1'b0, '0);
      if (done === 1'b1) ndone++;
      checks++; if (done !== pv[4]) begin failures++; $display("FAIL b2b_done cyc %0d got %b want %b", i, done, pv[4]); end
      checks++; if (result !== hold) begin failures++; $display("FAIL b2b_result cyc %0d got %h want %h", i, result, hold); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0);
      if (done === 1'b1) ndone++;
      checks++; if (result !== hold) begin failures++; $display("FAIL b2b_tail_result cyc %0d got %h want %h", i, result, hold); end
    end
    checks++; if (ndone != 4) begin failures++; $display("FAIL b2b_count got %0d want 4", ndone); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (i < 396 && $urandom_range(3) != 0) step(1'b1, rand_raw());
      else                                   step(1'b0, rand_raw());
      checks++; if (done !== pv[4]) begin failures++; $display("FAIL rnd_done cyc %0d got %b want %b", i, done, pv[4]); end
      checks++; if (result !== hold) begin failures++; $display("FAIL rnd_result cyc %0d got %h want %h", i, result, hold); end
      checks++; if (sat_cnt !== pc[4]) begin failures++; $display("FAIL rnd_sat_cnt cyc %0d got %h want %h", i, sat_cnt, pc[4]); end
    end
  endtask

  task automatic test_reset_midflight();
    step(1'b1, mk(0, 300, 54'h0, 0, 0));
    step(1'b1, mk(0, 17, 54'h3, 0, 0));
    @(posedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_result got %h want 0", result); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got %b want 0", done); end
    checks++; if (sat_cnt !== 16'h0) begin failures++; $display("FAIL rst_mid_sat_cnt got %h want 0", sat_cnt); end
    clear_model();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_drop_done cyc %0d got %b want 0", i, done); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_drop_result cyc %0d got %h want 0", i, result); end
      checks++; if (sat_cnt !== 16'h0) begin failures++; $display("FAIL rst_drop_sat_cnt cyc %0d got %h want 0", i, sat_cnt); end
    end
  endtask

  task automatic test_sat_ceiling();
    for (int i = 0; i < 65535; i++) step(1'b1, mk(0, 300, 54'h0, 0, 0));
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    checks++; if (sat_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_fill got %h want ffff", sat_cnt); end
    step(1'b1, mk(0, 300, 54'h0, 0, 0));
    for (int i = 0; i < 4; i++) step(1'b0, '0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sat_last_done got %b want 1", done); end
    checks++; if (result !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_last_result got %h want 7fffffff", result); end
    checks++; if (sat_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got %h want ffff", sat_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_sat_ceiling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
